// File: rtl/geofence_poly.sv
// -----------------------------------------------------------------------------
// geofence_poly
//
// Convex-polygon geofence tester. A job is one target point P followed by NV
// polygon vertices, in any order, over a valid/ready stream. The block orders
// the vertices counter-clockwise around the first vertex with a bubble sort
// that compares by cross product. It then tests P against every polygon edge
// and returns an inside / outside / on-edge verdict as a one-cycle strobe.
//
// Parameters
//   CW             coordinate width, unsigned, 4..16
//   NV             polygon vertex count, 3..8
//   ONEDGE_INSIDE  1: a point on an edge or vertex reports is_inside=1
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset; aborts any job in flight
//   in_valid   in   X/Y beat valid
//   in_ready   out  beat accepted when in_valid & in_ready (high only in LOAD)
//   X, Y       in   unsigned coordinates; beat 0 = P, beats 1..NV = vertices
//   out_valid  out  one-cycle result strobe
//   is_inside  out  verdict, qualified by out_valid (0 otherwise)
//   on_edge    out  P lies on an edge or vertex, qualified by out_valid
//
// Timing: out_valid rises (NV-2)^2 + NV + 1 edges after the edge that accepts
// the last vertex. The edge test is pipelined. Each cross product is
// registered before it updates the sticky flags, so TEST holds for NV
// evaluation cycles plus one drain cycle. in_ready returns in the cycle after
// the result strobe.
// -----------------------------------------------------------------------------
module geofence_poly #(
  parameter int CW            = 10,
  parameter int NV            = 6,
  parameter bit ONEDGE_INSIDE = 1'b0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] X,
  input  logic [CW-1:0] Y,
  output logic          out_valid,
  output logic          is_inside,
  output logic          on_edge
);

  // Vertex index width, beat/test counter width (counts up to NV), and the
  // exact signed widths of coordinate differences and cross products.
  localparam int VW = $clog2(NV);
  localparam int BW = $clog2(NV + 1);
  localparam int DW = CW + 1;
  localparam int PW = 2 * CW + 2;

  typedef enum logic [1:0] {
    S_LOAD,
    S_SORT,
    S_TEST,
    S_DONE
  } state_t;

  // Signed difference a - b of two unsigned coordinates. One extra bit covers
  // the full range -(2^CW-1) .. +(2^CW-1).
  function automatic logic signed [DW-1:0] sdiff(input logic [CW-1:0] a,
                                                 input logic [CW-1:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  // cross(a, b) = ax*by - ay*bx. Each product magnitude is below 2^(2CW), so
  // the difference of two products fits in PW signed bits with no overflow.
  function automatic logic signed [PW-1:0] cross2(input logic signed [DW-1:0] ax,
                                                  input logic signed [DW-1:0] ay,
                                                  input logic signed [DW-1:0] bx,
                                                  input logic signed [DW-1:0] by);
    logic signed [PW-1:0] p_a;
    logic signed [PW-1:0] p_b;
    p_a = PW'(ax) * PW'(by);
    p_b = PW'(ay) * PW'(bx);
    return p_a - p_b;
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_in_ready;
  logic [BW-1:0]        r_cnt;        // beat counter 0..NV
  logic [CW-1:0]        r_px;
  logic [CW-1:0]        r_py;
  logic [CW-1:0]        r_vx [NV];
  logic [CW-1:0]        r_vy [NV];
  logic [VW-1:0]        r_step;       // bubble-sort step index i, 1..NV-2
  logic [VW-1:0]        r_pass;       // bubble-sort pass, 0..NV-3
  logic [BW-1:0]        r_k;          // edge index in TEST, 0..NV (NV = drain)
  logic signed [PW-1:0] r_c;          // registered edge cross product
  logic                 r_c_vld;
  logic                 r_any_neg;
  logic                 r_any_zero;

  // ---------------------------------------------------------------------------
  // Control decodes
  // ---------------------------------------------------------------------------
  logic w_beat;
  logic w_load_last;
  logic w_sort_last;
  logic w_test_last;

  assign w_beat      = in_valid && r_in_ready && (r_state == S_LOAD);
  assign w_load_last = w_beat && (r_cnt == BW'(NV));
  assign w_sort_last = (r_step == VW'(NV - 2)) && (r_pass == VW'(NV - 3));
  assign w_test_last = (r_k == BW'(NV));

  // ---------------------------------------------------------------------------
  // Sort datapath: compare pair (i, i+1) around pivot v[0]
  // ---------------------------------------------------------------------------
  logic [VW-1:0]        w_si;
  logic [VW-1:0]        w_sj;
  logic signed [PW-1:0] w_sort_cross;
  logic                 w_swap;

  assign w_si         = r_step;
  assign w_sj         = r_step + VW'(1);
  assign w_sort_cross = cross2(sdiff(r_vx[w_si], r_vx[0]), sdiff(r_vy[w_si], r_vy[0]),
                               sdiff(r_vx[w_sj], r_vx[0]), sdiff(r_vy[w_sj], r_vy[0]));
  // A negative cross product means v[i+1] is clockwise of v[i] about the pivot.
  assign w_swap       = (r_state == S_SORT) && w_sort_cross[PW-1];

  // ---------------------------------------------------------------------------
  // Edge-test datapath: c[k] = cross(v[k+1]-v[k], P-v[k]), k+1 wraps to 0
  // ---------------------------------------------------------------------------
  logic [VW-1:0]        w_tk;
  logic [VW-1:0]        w_tn;
  logic signed [PW-1:0] w_test_cross;

  // During the drain cycle r_k equals NV. Clamping keeps the read in range.
  assign w_tk = (r_k < BW'(NV))      ? VW'(r_k)            : '0;
  assign w_tn = (r_k >= BW'(NV - 1)) ? '0                  : VW'(r_k + BW'(1));

  assign w_test_cross = cross2(sdiff(r_vx[w_tn], r_vx[w_tk]), sdiff(r_vy[w_tn], r_vy[w_tk]),
                               sdiff(r_px, r_vx[w_tk]),       sdiff(r_py, r_vy[w_tk]));

  logic [VW-1:0] w_load_idx;
  assign w_load_idx = VW'(r_cnt - BW'(1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_LOAD;
      r_in_ready <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register in this block samples pre-edge values.
      r_state    <= w_state_nxt;
      // Registered so that in_ready is 0 during reset and rises on the edge
      // that enters LOAD.
      r_in_ready <= (w_state_nxt == S_LOAD);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first, so no path through this block leaves
    // w_state_nxt unassigned and no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      S_LOAD: if (w_load_last) w_state_nxt = S_SORT;
      S_SORT: if (w_sort_last) w_state_nxt = S_TEST;
      S_TEST: if (w_test_last) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_LOAD;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = r_in_ready;
    out_valid = 1'b0;
    is_inside = 1'b0;
    on_edge   = 1'b0;
    if (r_state == S_DONE) begin
      out_valid = 1'b1;
      on_edge   = !r_any_neg && r_any_zero;
      is_inside = !r_any_neg && (!r_any_zero || ONEDGE_INSIDE);
    end
  end

  // ---------------------------------------------------------------------------
  // Beat counter. A reset mid-load zeroes it, which discards the partial set.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_beat) begin
      r_cnt <= w_load_last ? '0 : r_cnt + BW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Point and vertex storage
  // ---------------------------------------------------------------------------
  // NOTE: storage has no reset. Every entry is written during LOAD before
  // SORT or TEST reads it, so resetting it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (w_beat && (r_cnt == '0)) begin
      r_px <= X;
      r_py <= Y;
    end else if (w_beat) begin
      r_vx[w_load_idx] <= X;
      r_vy[w_load_idx] <= Y;
    end else if (w_swap) begin
      r_vx[w_si] <= r_vx[w_sj];
      r_vy[w_si] <= r_vy[w_sj];
      r_vx[w_sj] <= r_vx[w_si];
      r_vy[w_sj] <= r_vy[w_si];
    end
  end

  // ---------------------------------------------------------------------------
  // Sort sequencing: NV-2 passes of NV-2 steps
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_step <= '0;
      r_pass <= '0;
    end else if (w_load_last) begin
      r_step <= VW'(1);
      r_pass <= '0;
    end else if (r_state == S_SORT) begin
      if (r_step == VW'(NV - 2)) begin
        r_step <= VW'(1);
        r_pass <= r_pass + VW'(1);
      end else begin
        r_step <= r_step + VW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Edge test: one cross product per cycle, registered, then folded into the
  // sticky flags one cycle later. The flags clear on entry to TEST.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_k        <= '0;
      r_c        <= '0;
      r_c_vld    <= 1'b0;
      r_any_neg  <= 1'b0;
      r_any_zero <= 1'b0;
    end else begin
      r_c     <= w_test_cross;
      r_c_vld <= (r_state == S_TEST) && (r_k < BW'(NV));
      if ((r_state == S_SORT) && w_sort_last) begin
        r_k        <= '0;
        r_any_neg  <= 1'b0;
        r_any_zero <= 1'b0;
      end else begin
        if ((r_state == S_TEST) && !w_test_last) begin
          r_k <= r_k + BW'(1);
        end
        if (r_c_vld) begin
          r_any_neg  <= r_any_neg  | r_c[PW-1];
          r_any_zero <= r_any_zero | (r_c == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_geofence_poly.sv
// -----------------------------------------------------------------------------
// tb_geofence_poly
//
// Three instances: u_a (CW=10, NV=6, ONEDGE_INSIDE=0) and u_b (same with
// ONEDGE_INSIDE=1) share one input stream; u_3 (CW=4, NV=3) has its own.
// 'sel' routes the driven stream to the NV=6 pair (0) or to u_3 (1).
// The reference model does not sort. It finds the hull edges directly: an
// ordered vertex pair is a counter-clockwise edge when every other vertex lies
// strictly to its left. P is then classified against those edges.
// -----------------------------------------------------------------------------
module tb_geofence_poly;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       sel;
  logic       drv_valid;
  logic [9:0] drv_x, drv_y;

  logic in_valid_a, in_valid_3;
  logic [3:0] x3, y3;
  assign in_valid_a = drv_valid & ~sel;
  assign in_valid_3 = drv_valid & sel;
  assign x3 = drv_x[3:0];
  assign y3 = drv_y[3:0];

  logic rdy_a, ov_a, ins_a, edg_a;
  logic rdy_b, ov_b, ins_b, edg_b;
  logic rdy_3, ov_3, ins_3, edg_3;

  geofence_poly #(.CW(10), .NV(6), .ONEDGE_INSIDE(1'b0)) u_a (
    .clk(clk), .reset_n(rst_n), .in_valid(in_valid_a), .in_ready(rdy_a),
    .X(drv_x), .Y(drv_y), .out_valid(ov_a), .is_inside(ins_a), .on_edge(edg_a));

  geofence_poly #(.CW(10), .NV(6), .ONEDGE_INSIDE(1'b1)) u_b (
    .clk(clk), .reset_n(rst_n), .in_valid(in_valid_a), .in_ready(rdy_b),
    .X(drv_x), .Y(drv_y), .out_valid(ov_b), .is_inside(ins_b), .on_edge(edg_b));

  geofence_poly #(.CW(4), .NV(3), .ONEDGE_INSIDE(1'b0)) u_3 (
    .clk(clk), .reset_n(rst_n), .in_valid(in_valid_3), .in_ready(rdy_3),
    .X(x3), .Y(y3), .out_valid(ov_3), .is_inside(ins_3), .on_edge(edg_3));

  logic rdy, ov;
  assign rdy = sel ? rdy_3 : rdy_a;
  assign ov  = sel ? ov_3  : ov_a;

  int n_vec = 0;
  int n_err = 0;

  // Current polygon (first n entries used).
  int vx[8];
  int vy[8];

  function automatic int xprod(input int ax, input int ay, input int bx, input int by);
    return ax * by - ay * bx;
  endfunction

  function automatic void model(input int n, input int px, input int py, input bit oei,
                                output bit ins, output bit edg);
    bit neg = 1'b0;
    bit zer = 1'b0;
    for (int a = 0; a < n; a++) begin
      for (int b = 0; b < n; b++) begin
        bit hull;
        int c;
        if (a == b) continue;
        hull = 1'b1;
        for (int m = 0; m < n; m++) begin
          if (m == a || m == b) continue;
          if (xprod(vx[b] - vx[a], vy[b] - vy[a], vx[m] - vx[a], vy[m] - vy[a]) <= 0)
            hull = 1'b0;
        end
        if (hull) begin
          c = xprod(vx[b] - vx[a], vy[b] - vy[a], px - vx[a], py - vy[a]);
          if (c < 0)  neg = 1'b1;
          if (c == 0) zer = 1'b1;
        end
      end
    end
    edg = !neg && zer;
    ins = !neg && (!zer || oei);
  endfunction

  // Drive one beat and wait for it to be accepted; ok=0 if it never is.
  task automatic send_beat(input int x, input int y, input bit gaps, output bit ok);
    int guard;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    drv_x     = x[9:0];
    drv_y     = y[9:0];
    drv_valid = 1'b1;
    ok        = 1'b0;
    guard     = 0;
    while (!ok && guard < 50) begin
      @(negedge clk);
      if (rdy) ok = 1'b1;
      @(posedge clk);
      #1;
      guard++;
    end
    drv_valid = 1'b0;
  endtask

  // Load P plus n vertices, then measure latency and check the verdict.
  task automatic run_job(input int n, input int px, input int py, input bit gaps,
                         input bit junk, input string tag);
    bit e_in0, e_edg0, e_in1, e_edg1, ok, load_ok, got;
    int lat, exp_lat, qual_bad;
    model(n, px, py, 1'b0, e_in0, e_edg0);
    model(n, px, py, 1'b1, e_in1, e_edg1);
    exp_lat = (n - 2) * (n - 2) + n + 1;
    load_ok = 1'b1;
    send_beat(px, py, gaps, ok);
    load_ok &= ok;
    for (int i = 0; i < n; i++) begin
      send_beat(vx[i], vy[i], gaps, ok);
      load_ok &= ok;
    end
    n_vec++;
    if (load_ok !== 1'b1) begin
      n_err++;
      $display("FAIL %s load_handshake: accepted=%0b required=1", tag, load_ok);
    end
    lat = 0; got = 1'b0; qual_bad = 0;
    while (!got && lat < 200) begin
      if (junk && lat < 8) begin
        drv_valid = 1'b1;
        drv_x     = 10'($urandom);
        drv_y     = 10'($urandom);
      end else begin
        drv_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (ov) got = 1'b1;
      else if (ins_a || edg_a || ins_b || edg_b || ins_3 || edg_3) qual_bad++;
    end
    drv_valid = 1'b0;
    n_vec++;
    if (!got || lat != exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d (strobe=%0b) required %0d", tag, lat, got, exp_lat);
    end
    n_vec++;
    if (qual_bad != 0) begin
      n_err++;
      $display("FAIL %s unqualified_result: %0d cycles with result bits set, required 0", tag, qual_bad);
    end
    if (sel) begin
      n_vec++;
      if ({ins_3, edg_3} !== {e_in0, e_edg0}) begin
        n_err++;
        $display("FAIL %s verdict_nv3: inside/edge=%b%b required %b%b", tag, ins_3, edg_3, e_in0, e_edg0);
      end
    end else begin
      n_vec++;
      if ({ov_b, ins_a, edg_a} !== {1'b1, e_in0, e_edg0}) begin
        n_err++;
        $display("FAIL %s verdict_a: strobe_b/inside/edge=%b%b%b required 1%b%b", tag, ov_b, ins_a, edg_a, e_in0, e_edg0);
      end
      n_vec++;
      if ({ins_b, edg_b} !== {e_in1, e_edg1}) begin
        n_err++;
        $display("FAIL %s verdict_b: inside/edge=%b%b required %b%b", tag, ins_b, edg_b, e_in1, e_edg1);
      end
    end
    @(posedge clk);
    #1;
    n_vec++;
    if ({ov, rdy} !== 2'b01) begin
      n_err++;
      $display("FAIL %s after_done: out_valid/in_ready=%b%b required 01", tag, ov, rdy);
    end
  endtask

  task automatic set_hexagon();
    vx = '{200, 100, 300, 200, 100, 300, 0, 0};
    vy = '{100, 250, 150, 300, 150, 250, 0, 0};
  endtask

  // Random convex hexagon: one of two templates, scaled, translated and
  // shuffled. ex/ey returns a point exactly on one of its edges.
  task automatic make_poly(output int ex, output int ey);
    int tx[6], ty[6];
    int s, cx, cy, k, k1, j, t;
    if ($urandom_range(0, 1) == 0) begin
      tx = '{0, 100, 100, 0, -100, -100};
      ty = '{-100, -50, 50, 100, 50, -50};
    end else begin
      tx = '{0, 90, 130, 40, -80, -120};
      ty = '{-120, -90, 20, 110, 90, -30};
    end
    s  = $urandom_range(1, 3);
    cx = $urandom_range(400, 623);
    cy = $urandom_range(400, 623);
    k  = $urandom_range(0, 5);
    k1 = (k + 1) % 6;
    ex = cx + s * ((tx[k] + tx[k1]) / 2);
    ey = cy + s * ((ty[k] + ty[k1]) / 2);
    for (int i = 0; i < 6; i++) begin
      vx[i] = cx + s * tx[i];
      vy[i] = cy + s * ty[i];
    end
    for (int i = 5; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = vx[i]; vx[i] = vx[j]; vx[j] = t;
      t = vy[i]; vy[i] = vy[j]; vy[j] = t;
    end
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if ({rdy_a, ov_a, ins_a, edg_a} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_a: ready/valid/inside/edge=%b required 0000", {rdy_a, ov_a, ins_a, edg_a});
    end
    n_vec++;
    if ({rdy_b, ov_b, ins_b, edg_b} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_b: ready/valid/inside/edge=%b required 0000", {rdy_b, ov_b, ins_b, edg_b});
    end
    n_vec++;
    if ({rdy_3, ov_3, ins_3, edg_3} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_3: ready/valid/inside/edge=%b required 0000", {rdy_3, ov_3, ins_3, edg_3});
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_hexagon();
    sel = 1'b0;
    set_hexagon();
    run_job(6, 200, 200, 1'b0, 1'b0, "hex_inside");
    run_job(6, 400, 200, 1'b0, 1'b0, "hex_outside");
    run_job(6, 300, 200, 1'b0, 1'b0, "hex_on_edge");
    run_job(6, 200, 100, 1'b0, 1'b0, "hex_vertex");
  endtask

  task automatic test_extremes();
    sel = 1'b0;
    vx = '{1023, 0, 600, 400, 1023, 0, 0, 0};
    vy = '{400, 0, 0, 1023, 1023, 600, 0, 0};
    run_job(6, 0, 0, 1'b0, 1'b0, "ext_origin");
    run_job(6, 1023, 1023, 1'b0, 1'b0, "ext_max");
    run_job(6, 1023, 0, 1'b0, 1'b0, "ext_corner_out");
    run_job(6, 512, 512, 1'b0, 1'b0, "ext_center");
    run_job(6, 1023, 700, 1'b0, 1'b0, "ext_edge");
  endtask

  task automatic test_triangle();
    sel = 1'b1;
    vx = '{0, 15, 0, 0, 0, 0, 0, 0};
    vy = '{0, 0, 15, 0, 0, 0, 0, 0};
    run_job(3, 15, 15, 1'b0, 1'b0, "tri_outside");
    run_job(3, 1, 1, 1'b0, 1'b0, "tri_inside");
    run_job(3, 7, 8, 1'b0, 1'b0, "tri_hyp_edge");
    run_job(3, 0, 0, 1'b0, 1'b0, "tri_vertex");
    vx = '{0, 0, 15, 0, 0, 0, 0, 0};
    vy = '{0, 15, 0, 0, 0, 0, 0, 0};
    run_job(3, 2, 3, 1'b0, 1'b0, "tri_cw_order");
  endtask

  task automatic test_stall_gaps();
    int ex, ey;
    sel = 1'b0;
    set_hexagon();
    run_job(6, 200, 200, 1'b1, 1'b0, "gap_hex_inside");
    run_job(6, 300, 200, 1'b1, 1'b0, "gap_hex_edge");
    for (int i = 0; i < 6; i++) begin
      make_poly(ex, ey);
      run_job(6, ex, ey, 1'b1, 1'b0, "gap_rand_edge");
    end
  endtask

  task automatic test_ignore_busy();
    sel = 1'b0;
    set_hexagon();
    run_job(6, 200, 200, 1'b0, 1'b1, "busy_junk_in");
    run_job(6, 400, 200, 1'b0, 1'b1, "busy_junk_out");
  endtask

  task automatic test_reset_abort();
    bit ok;
    int spurious;
    sel = 1'b0;
    set_hexagon();
    // Abort mid-LOAD: the partial beats must be discarded.
    send_beat(1000, 1000, 1'b0, ok);
    send_beat(vx[0], vy[0], 1'b0, ok);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({rdy_a, rdy_b} !== 2'b00) begin
      n_err++;
      $display("FAIL abort_load_ready: in_ready a/b=%b required 00", {rdy_a, rdy_b});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_job(6, 200, 200, 1'b0, 1'b0, "after_load_abort");
    // Abort mid-SORT.
    send_beat(400, 200, 1'b0, ok);
    for (int i = 0; i < 6; i++) send_beat(vx[i], vy[i], 1'b0, ok);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({rdy_a, ov_a, ins_a, edg_a, rdy_b, ov_b, ins_b, edg_b} !== 8'h00) begin
      n_err++;
      $display("FAIL abort_sort_outputs: %b required 00000000",
               {rdy_a, ov_a, ins_a, edg_a, rdy_b, ov_b, ins_b, edg_b});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    spurious = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ov_a || ov_b) spurious++;
    end
    n_vec++;
    if (spurious != 0) begin
      n_err++;
      $display("FAIL abort_sort_stale_strobe: %0d strobes required 0", spurious);
    end
    run_job(6, 200, 200, 1'b0, 1'b0, "after_sort_abort");
  endtask

  task automatic test_random_jobs();
    int ex, ey, px, py, mode, j;
    sel = 1'b0;
    for (int r = 0; r < 25; r++) begin
      make_poly(ex, ey);
      mode = $urandom_range(0, 4);
      if (mode == 0) begin
        px = ex; py = ey;
      end else if (mode == 1) begin
        j = $urandom_range(0, 5);
        px = vx[j]; py = vy[j];
      end else begin
        px = $urandom_range(0, 1023);
        py = $urandom_range(0, 1023);
        if (mode > 2) begin
          px = 512 + (px - 512) / 2;
          py = 512 + (py - 512) / 2;
        end
      end
      run_job(6, px, py, 1'($urandom_range(0, 1)), 1'b0, "rand_nv6");
    end
    sel = 1'b1;
    for (int r = 0; r < 20; r++) begin
      do begin
        for (int i = 0; i < 3; i++) begin
          vx[i] = $urandom_range(0, 15);
          vy[i] = $urandom_range(0, 15);
        end
      end while (xprod(vx[1] - vx[0], vy[1] - vy[0], vx[2] - vx[0], vy[2] - vy[0]) == 0);
      run_job(3, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
              1'b0, "rand_nv3");
    end
  endtask

  task automatic test_back_to_back();
    int ex, ey;
    sel = 1'b0;
    for (int r = 0; r < 4; r++) begin
      make_poly(ex, ey);
      run_job(6, ex + 1, ey, 1'b0, 1'b0, "b2b");
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    sel       = 1'b0;
    drv_valid = 1'b0;
    drv_x     = '0;
    drv_y     = '0;
    test_reset();
    test_hexagon();
    test_extremes();
    test_triangle();
    test_stall_gaps();
    test_ignore_busy();
    test_reset_abort();
    test_random_jobs();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
